// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Default widths, the ECALL encoding and the fetch FSM state encoding.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 32;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for {pc, instr} pairs; head is read straight from storage, flush empties it in one edge.
// Push lands one edge after request; a push into a full FIFO is taken only alongside a pop.
module fetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop      = i_pop && (r_count != '0);
  assign w_push     = i_push && ((r_count < CNT_W'(DEPTH)) || w_pop);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC/FSM drive the instruction memory, words are buffered and offered on valid/ready; first word valid after edge 1.
// Stalls the PC when the buffer is full and ready is low; FETCH_PERF_CNT_EN adds fetched/flushed counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int DATA_W     = FETCH_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetched_cnt_o,
  output logic [31:0]       flushed_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                     r_state;
  logic [ADDR_W-1:0]          r_pc;
  logic [CNT_W-1:0]           w_count;
  logic [ADDR_W+DATA_W-1:0]   w_head;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_is_ecall;

  assign out_valid_o = (w_count != '0);
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_push      = (r_state == RUN) && ((w_count < CNT_W'(FIFO_DEPTH)) || w_pop) && !redirect_i;
  assign w_is_ecall  = (mem_rdata_i == DATA_W'(ECALL_INSTR));

  assign mem_addr_o            = r_pc;
  assign halted_o              = (r_state == HALT);
  assign {out_pc_o, out_instr_o} = w_head;

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat ({r_pc, mem_rdata_i}),
    .i_pop      (w_pop),
    .i_flush    (redirect_i),
    .o_count    (w_count),
    .o_head_dat (w_head)
  );

  // Redirect overrides every state, including the start-up IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else if (redirect_i) begin
      r_state <= RUN;
      r_pc    <= redirect_addr_i;
    end else begin
      unique case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (w_push) begin
            r_pc <= r_pc + ADDR_W'(1);
            if (w_is_ecall) begin
              r_state <= HALT;
            end
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] w_dropped;

  // An entry popped in the redirect cycle was delivered, so it is not a flush loss.
  assign w_dropped = w_count - CNT_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_cnt_o <= '0;
      flushed_cnt_o <= '0;
    end else begin
      if (w_push) begin
        fetched_cnt_o <= fetched_cnt_o + 32'd1;
      end
      if (redirect_i) begin
        flushed_cnt_o <= flushed_cnt_o + 32'(w_dropped);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every negedge, plus directed literal checks.
// Inputs change 1 time unit after posedge; outputs and handshakes are sampled at negedge.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] w;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [7:0]  raddr;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] flushed_cnt;
`endif

  logic [31:0] tb_mem [256];
  int          n_chk = 0;
  int          n_fail = 0;

  ent_t        m_q[$];
  logic [7:0]  m_pc = 8'd0;
  bit          m_started = 1'b0;
  bit          m_halted = 1'b0;
  int unsigned m_fetched = 0;
  int unsigned m_flushed = 0;
  ent_t        dlv[$];

  assign mem_rdata = tb_mem[mem_addr];

  instr_fetch_unit #(
    .ADDR_W     (8),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr_o      (mem_addr),
    .mem_rdata_i     (mem_rdata),
    .redirect_i      (redirect),
    .redirect_addr_i (raddr),
    .out_valid_o     (valid),
    .out_ready_i     (ready),
    .out_instr_o     (instr),
    .out_pc_o        (pc),
    .halted_o        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt_o   (fetched_cnt),
    .flushed_cnt_o   (flushed_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dlv(input string name, input int idx, input logic [7:0] epc, input logic [31:0] ew);
    if (idx >= dlv.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: delivery %0d missing (only %0d) expected pc %0h", name, idx, dlv.size(), epc);
    end else begin
      check({name, "_pc"}, 32'(dlv[idx].pc), 32'(epc));
      check({name, "_instr"}, dlv[idx].w, ew);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Reference model: a queue of {pc, word} pairs advanced once per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc      = 8'd0;
      m_started = 1'b0;
      m_halted  = 1'b0;
      m_fetched = 0;
      m_flushed = 0;
    end else begin
      automatic bit pop = ready && (m_q.size() != 0);
      if (redirect) begin
        m_flushed += m_q.size() - (pop ? 1 : 0);
        m_q.delete();
        m_pc      = raddr;
        m_started = 1'b1;
        m_halted  = 1'b0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (!m_started) begin
          m_started = 1'b1;
        end else if (!m_halted && m_q.size() < DEPTH) begin
          m_q.push_back('{pc: m_pc, w: tb_mem[m_pc]});
          m_fetched++;
          if (tb_mem[m_pc] == ECALL) m_halted = 1'b1;
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(valid), 32'(m_q.size() != 0));
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("halted", 32'(halted), 32'(m_halted));
    if (m_q.size() != 0) begin
      check("head_pc", 32'(pc), 32'(m_q[0].pc));
      check("head_instr", instr, m_q[0].w);
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetched_cnt", fetched_cnt, m_fetched);
    check("flushed_cnt", flushed_cnt, m_flushed);
`endif
    if (valid && ready) dlv.push_back('{pc: pc, w: instr});
  end

  initial begin
    rst      = 1'b1;
    ready    = 1'b0;
    redirect = 1'b0;
    raddr    = 8'd0;
    for (int i = 0; i < 256; i++) begin
      automatic logic [31:0] w = $urandom;
      if (w == ECALL) w = w ^ 32'd1;
      tb_mem[i] = w;
    end
    tb_mem[0] = 32'h11;
    tb_mem[1] = 32'h22;
    tb_mem[2] = 32'h33;
    tb_mem[3] = 32'h44;
    step(2);

    // 1: streaming with ready high
    check("t1_reset_valid", 32'(valid), 32'd0);
    check("t1_reset_addr", 32'(mem_addr), 32'd0);
    ready = 1'b1;
    apply_reset();
    dlv.delete();
    step(1);
    check("t1_edge0_valid", 32'(valid), 32'd0);
    step(1);
    check("t1_edge1_valid", 32'(valid), 32'd1);
    check("t1_edge1_pc", 32'(pc), 32'd0);
    check("t1_edge1_instr", instr, 32'h11);
    step(3);
    check_dlv("t1_d0", 0, 8'd0, 32'h11);
    check_dlv("t1_d1", 1, 8'd1, 32'h22);
    check_dlv("t1_d2", 2, 8'd2, 32'h33);

    // 2: backpressure then release
    ready = 1'b0;
    apply_reset();
    step(6);
    check("t2_full_valid", 32'(valid), 32'd1);
    check("t2_full_pc", 32'(pc), 32'd0);
    check("t2_full_instr", instr, 32'h11);
    check("t2_full_addr", 32'(mem_addr), 32'd2);
    ready = 1'b1;
    dlv.delete();
    step(3);
    check("t2_count", dlv.size(), 32'd3);
    check_dlv("t2_d0", 0, 8'd0, 32'h11);
    check_dlv("t2_d1", 1, 8'd1, 32'h22);
    check_dlv("t2_d2", 2, 8'd2, 32'h33);

    // 3: redirect on a full FIFO with a coincident pop
    ready = 1'b0;
    apply_reset();
    step(4);
    ready    = 1'b1;
    redirect = 1'b1;
    raddr    = 8'h40;
    dlv.delete();
    step(1);
    redirect = 1'b0;
    check("t3_flush_valid", 32'(valid), 32'd0);
    check("t3_flush_addr", 32'(mem_addr), 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check("t3_flushed_cnt", flushed_cnt, 32'd1);
`endif
    step(1);
    check("t3_tgt_valid", 32'(valid), 32'd1);
    check("t3_tgt_pc", 32'(pc), 32'h40);
    check("t3_tgt_instr", instr, tb_mem[8'h40]);
    check("t3_dlv_count", dlv.size(), 32'd1);
    check_dlv("t3_d0", 0, 8'd0, 32'h11);

    // 4: ECALL halts, redirect resumes
    tb_mem[5] = ECALL;
    ready = 1'b1;
    apply_reset();
    dlv.delete();
    step(12);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_valid", 32'(valid), 32'd0);
    check("t4_dlv_count", dlv.size(), 32'd6);
    check_dlv("t4_ecall", 5, 8'd5, ECALL);
    redirect = 1'b1;
    raddr    = 8'h10;
    step(1);
    redirect = 1'b0;
    check("t4_unhalt", 32'(halted), 32'd0);
    step(1);
    check("t4_tgt_pc", 32'(pc), 32'h10);
    check("t4_tgt_instr", instr, tb_mem[8'h10]);

    // 5: PC wrap
    redirect = 1'b1;
    raddr    = 8'hFE;
    step(1);
    redirect = 1'b0;
    dlv.delete();
    step(5);
    check_dlv("t5_d0", 0, 8'hFE, tb_mem[8'hFE]);
    check_dlv("t5_d1", 1, 8'hFF, tb_mem[8'hFF]);
    check_dlv("t5_d2", 2, 8'h00, 32'h11);
    check_dlv("t5_d3", 3, 8'h01, 32'h22);

    // random traffic with redirects and an ECALL at 0x80
    tb_mem[5]    = 32'h1234_5678;
    tb_mem[8'h80] = ECALL;
    for (int i = 0; i < 400; i++) begin
      ready    = ($urandom_range(3) != 0);
      redirect = ($urandom_range(19) == 0);
      raddr    = 8'($urandom);
      step(1);
    end
    redirect = 1'b0;

    // 6: asynchronous reset while halted with a full FIFO
    ready    = 1'b0;
    redirect = 1'b1;
    raddr    = 8'h7F;
    step(1);
    redirect = 1'b0;
    step(5);
    check("t6_pre_halted", 32'(halted), 32'd1);
    check("t6_pre_valid", 32'(valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(valid), 32'd0);
    check("t6_async_halted", 32'(halted), 32'd0);
    check("t6_async_pc", 32'(pc), 32'd0);
    check("t6_async_instr", instr, 32'd0);
    check("t6_async_addr", 32'(mem_addr), 32'd0);
    #1 rst = 1'b0;
    ready = 1'b1;
    step(1);
    check("t6_edge0_valid", 32'(valid), 32'd0);
    step(1);
    check("t6_edge1_valid", 32'(valid), 32'd1);
    check("t6_edge1_pc", 32'(pc), 32'd0);
    check("t6_edge1_instr", instr, 32'h11);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
